// File: rtl/alu_mc_pkg.sv
// alu_mc shared types: operation codes, FSM states, iterative-op selector.
package alu_mc_pkg;

  typedef enum logic [4:0] {
    M_ADD   = 5'd0,
    M_SUB   = 5'd1,
    M_AND   = 5'd2,
    M_OR    = 5'd3,
    M_XOR   = 5'd4,
    M_SLL   = 5'd5,
    M_SRL   = 5'd6,
    M_SRA   = 5'd7,
    M_SLTU  = 5'd8,
    M_SGEU  = 5'd9,
    M_EQ    = 5'd10,
    M_NE    = 5'd11,
    M_SLT   = 5'd12,
    M_SGE   = 5'd13,
    M_MUL   = 5'd14,
    M_MULHU = 5'd15,
    M_DIVU  = 5'd16,
    M_REMU  = 5'd17
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_MULHU = 2'd1,
    OP_DIVU  = 2'd2,
    OP_REMU  = 2'd3
  } iter_op_e;

  // Modes served by the multi-cycle engine.
  function automatic logic is_muldiv(input logic [4:0] m);
    return (m >= M_MUL) && (m <= M_REMU);
  endfunction

  // Modes 14..17 map onto iter ops 0..3 in order.
  function automatic iter_op_e iter_op(input logic [4:0] m);
    logic [4:0] d;
    d = m - M_MUL;
    return iter_op_e'(d[1:0]);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: one shift-add multiply or restoring-divide step per cycle.
// The first step is taken on the start edge straight from the inputs, so
// after WIDTH edges (cnt == WIDTH) the result sits in hi/lo.
// Multiply: {hi,lo} is the running product, lo starts as the multiplier.
// Divide:   hi is the partial remainder, lo shifts dividend out / quotient in.
module alu_mc_iter import alu_mc_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  iter_op_e         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH);

  iter_op_e         op_q, s_op;
  logic [WIDTH-1:0] a_q, b_q, hi, lo;
  logic [WIDTH-1:0] s_a, s_b, s_hi, s_lo, n_hi, n_lo;
  logic [WIDTH:0]   sum, shl, dif;
  logic [SHW:0]     cnt;
  logic             is_div;

  // Step source muxes between fresh operands (start) and the running state.
  always_comb begin
    s_op   = start ? op : op_q;
    s_a    = start ? a  : a_q;
    s_b    = start ? b  : b_q;
    is_div = (s_op == OP_DIVU) || (s_op == OP_REMU);
    s_hi   = start ? '0 : hi;
    s_lo   = start ? (is_div ? a : b) : lo;
    sum    = {1'b0, s_hi} + {1'b0, s_a & {WIDTH{s_lo[0]}}};
    shl    = {s_hi, s_lo[WIDTH-1]};
    dif    = shl - {1'b0, s_b};
    n_hi   = hi;
    n_lo   = lo;
    if (is_div) begin
      // Divide by zero falls out naturally: quotient all-ones, remainder a.
      if (shl >= {1'b0, s_b}) begin
        n_hi = dif[WIDTH-1:0];
        n_lo = {s_lo[WIDTH-2:0], 1'b1};
      end else begin
        n_hi = shl[WIDTH-1:0];
        n_lo = {s_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      n_hi = sum[WIDTH:1];
      n_lo = {sum[0], s_lo[WIDTH-1:1]};
    end
  end

  // Iteration state; cnt parks at 0 or LAST when no operation is running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= OP_MUL;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
    end else if (start || (cnt != '0 && cnt != LAST)) begin
      op_q <= s_op;
      a_q  <= s_a;
      b_q  <= s_b;
      hi   <= n_hi;
      lo   <= n_lo;
      cnt  <= start ? (SHW+1)'(1) : cnt + 1'b1;
    end
  end

  assign done   = (cnt == LAST);
  assign result = (op_q == OP_MUL || op_q == OP_DIVU) ? lo : hi;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU, single-cycle ops plus optional iterative mul/div.
// Build option: define ALU_MC_MULDIV_EN to build the multiply/divide engine;
// without it modes 14..17 return 0 with single-cycle latency.
module alu_mc import alu_mc_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic             zero,
  output logic             busy
);

  state_e           state, state_nxt;
  logic             load_x;
  logic [WIDTH-1:0] x_nxt, alu_res;
  logic [SHW-1:0]   sh;

  assign sh = b[SHW-1:0];

`ifdef ALU_MC_MULDIV_EN
  logic             iter_start, iter_done;
  logic [WIDTH-1:0] iter_res;

  alu_mc_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .op     (iter_op(mode)),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .result (iter_res)
  );
`endif

  // Single-cycle result; compares zero-extended, unlisted modes give 0.
  always_comb begin
    alu_res = '0;
    case (mode)
      M_ADD:   alu_res = a + b;
      M_SUB:   alu_res = a - b;
      M_AND:   alu_res = a & b;
      M_OR:    alu_res = a | b;
      M_XOR:   alu_res = a ^ b;
      M_SLL:   alu_res = a << sh;
      M_SRL:   alu_res = a >> sh;
      M_SRA:   alu_res = $signed(a) >>> sh;
      M_SLTU:  alu_res[0] = (a < b);
      M_SGEU:  alu_res[0] = (a >= b);
      M_EQ:    alu_res[0] = (a == b);
      M_NE:    alu_res[0] = (a != b);
      M_SLT:   alu_res[0] = ($signed(a) < $signed(b));
      M_SGE:   alu_res[0] = ($signed(a) >= $signed(b));
      default: alu_res = '0;
    endcase
  end

  // Next state and handshake outputs; in_ready is masked while in reset.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_x    = 1'b0;
    x_nxt     = alu_res;
`ifdef ALU_MC_MULDIV_EN
    iter_start = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
`ifdef ALU_MC_MULDIV_EN
          if (is_muldiv(mode)) begin
            state_nxt  = S_CALC;
            iter_start = 1'b1;
          end else
`endif
          begin
            state_nxt = S_DONE;
            load_x    = 1'b1;
          end
        end
      end
`ifdef ALU_MC_MULDIV_EN
      S_CALC: begin
        if (iter_done) begin
          state_nxt = S_DONE;
          load_x    = 1'b1;
          x_nxt     = iter_res;
        end
      end
`endif
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Result and zero flag are loaded together so they never disagree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x    <= '0;
      zero <= 1'b1;
    end else if (load_x) begin
      x    <= x_nxt;
      zero <= (x_nxt == '0);
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors into a scoreboard queue; a monitor pops and
// compares on every out_valid&&out_ready handshake.
module tb_alu_mc;
  import alu_mc_pkg::*;

`ifdef ALU_MC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [31:0] a, b, x;
  logic [4:0]  mode;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_md(input logic [4:0] m);
    return MD && (m >= 5'd14) && (m <= 5'd17);
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("x", x, e);
        chk("zero", zero, (e == 32'h0));
      end
    end
  end

  task automatic run_op(input logic [4:0] m, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ex, input int hold);
    int lat;
    bit bad;
    logic [31:0] xs;
    int exp_lat;
    exp_lat = is_md(m) ? 33 : 1;
    @(posedge clk); #1;
    in_valid = 1'b1; mode = m; a = av; b = bv;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    exp_q.push_back(ex);
    @(posedge clk); #1;
    // Garbage on the inputs while busy must not disturb anything.
    a = $urandom; b = $urandom; mode = 5'($urandom);
    lat = 0; bad = 0;
    while (lat < 100) begin
      @(negedge clk); lat++;
      if (in_ready) bad = 1;
      if (out_valid) break;
    end
    chk("latency", lat, exp_lat);
    xs = x;
    repeat (hold) begin
      @(negedge clk);
      if (x !== xs || in_ready || !out_valid) bad = 1;
    end
    chk("busy_hold", bad, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("back_idle", {busy, in_ready}, 2'b01);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_state", {busy, out_valid, zero}, 3'b001);
    chk("rst_x", x, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    run_op(M_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        0);
    run_op(M_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 5);
    run_op(M_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0);
    run_op(M_OR,   32'h12340000, 32'h00005678, 32'h12345678, 0);
    run_op(M_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0);
    run_op(M_SLL,  32'h1,        32'h21,       32'h2,        0);
    run_op(M_SRL,  32'h80000000, 32'h4,        32'h08000000, 0);
    run_op(M_SRA,  32'h80000000, 32'h24,       32'hF8000000, 0);
    run_op(M_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        0);
    run_op(M_SGEU, 32'hFFFFFFFF, 32'h1,        32'h1,        0);
    run_op(M_EQ,   32'd5,        32'd5,        32'h1,        0);
    run_op(M_NE,   32'd5,        32'd5,        32'h0,        0);
    run_op(M_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        0);
    run_op(M_SGE,  32'hFFFFFFFF, 32'h1,        32'h0,        0);
    run_op(5'd20,  32'h1234,     32'h5678,     32'h0,        0);
    run_op(M_MUL,   32'h10000,    32'h10000,    32'h0,                    0);
    run_op(M_MULHU, 32'h10000,    32'h10000,    MD ? 32'h1 : 32'h0,       0);
    run_op(M_MUL,   32'd7,        32'd6,        MD ? 32'd42 : 32'h0,      0);
    run_op(M_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, MD ? 32'hFFFFFFFE : 32'h0, 3);
    run_op(M_DIVU,  32'd100,      32'd7,        MD ? 32'd14 : 32'h0,      0);
    run_op(M_REMU,  32'd100,      32'd7,        MD ? 32'd2 : 32'h0,       0);
    run_op(M_DIVU,  32'd100,      32'd0,        MD ? 32'hFFFFFFFF : 32'h0, 0);
    run_op(M_REMU,  32'd100,      32'd0,        MD ? 32'd100 : 32'h0,     0);

    // Reset in the middle of a divide discards it.
    @(posedge clk); #1;
    in_valid = 1'b1; mode = M_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", {busy, out_valid, zero, in_ready}, 4'b0011);
    chk("mid_rst_x", x, 0);
    run_op(M_ADD, 32'd2, 32'd3, 32'd5, 0);

    chk("sb_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
